// File: rtl/rd_track_pipe_pkg.sv
// Shared defines for the rd tracking pipeline: width defaults and MEM-slot state encoding.
package rd_track_pipe_pkg;

    localparam int REG_IDX    = 5;
    localparam int DATA_LEN   = 64;
    localparam int DATA_W_DEF = DATA_LEN;
    localparam int IDX_W_DEF  = REG_IDX;

    typedef enum logic [1:0] {
        SLOT_EMPTY     = 2'd0,
        SLOT_READY     = 2'd1,
        SLOT_LOAD_WAIT = 2'd2
    } slot_state_e;

endpackage

// File: rtl/rd_track_pipe_slot.sv
// rd_slot: one pipeline entry (valid/idx/data) with clear > load > hold priority.
module rd_slot #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (load_i) begin
            r_valid <= valid_i;
            r_idx   <= valid_i ? idx_i  : '0;
            r_data  <= valid_i ? data_i : '0;
        end
    end

    assign valid_o = r_valid;
    assign idx_o   = r_idx;
    assign data_o  = r_data;

endmodule

// File: rtl/rd_track_pipe.sv
// Tracks the destination register through MEM and WB, offering forwarding views,
// the register-file write port, and load-use hazard detection.
module rd_track_pipe
    import rd_track_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic              ex_rd_we_i,
    input  logic              ex_is_load_i,
    input  logic [IDX_W-1:0]  ex_rd_idx_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              mem_load_valid_i,
    input  logic [DATA_W-1:0] mem_load_data_i,
    input  logic [IDX_W-1:0]  id_rs1_idx_i,
    input  logic [IDX_W-1:0]  id_rs2_idx_i,
    output logic [IDX_W-1:0]  rd_idx_ex_o,
    output logic [DATA_W-1:0] rd_ex_o,
    output logic [IDX_W-1:0]  rd_idx_mem_o,
    output logic [DATA_W-1:0] rd_mem_o,
    output logic              wb_we_o,
    output logic [IDX_W-1:0]  wb_idx_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              ex_ready_o,
    output logic              load_use_stall_o
);

    slot_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;

    logic              w_blocked, w_advance;
    logic              w_wb_load, w_wb_clear, w_wb_valid_in;
    logic [IDX_W-1:0]  w_wb_idx_in;
    logic [DATA_W-1:0] w_wb_data_in;
    logic              w_wb_valid;
    logic [IDX_W-1:0]  w_wb_idx;
    logic [DATA_W-1:0] w_wb_data;

    assign w_blocked = (r_state == SLOT_LOAD_WAIT) && !mem_load_valid_i;
    assign w_advance = !stall_i && !w_blocked;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SLOT_EMPTY;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_data;
        w_wb_load     = 1'b0;
        w_wb_clear    = 1'b0;
        w_wb_valid_in = 1'b0;
        w_wb_idx_in   = '0;
        w_wb_data_in  = '0;
        if (w_advance) begin
            w_wb_load = 1'b1;
            case (r_state)
                SLOT_READY: begin
                    w_wb_valid_in = 1'b1;
                    w_wb_idx_in   = r_idx;
                    w_wb_data_in  = r_data;
                end
                // Returning load data bypasses the MEM slot straight into WB.
                SLOT_LOAD_WAIT: begin
                    w_wb_valid_in = 1'b1;
                    w_wb_idx_in   = r_idx;
                    w_wb_data_in  = mem_load_data_i;
                end
                default: ;
            endcase
            if (flush_i || !ex_valid_i || !ex_rd_we_i || ex_rd_idx_i == '0) begin
                w_state_nxt = SLOT_EMPTY;
                w_idx_nxt   = '0;
                w_data_nxt  = '0;
            end else if (ex_is_load_i) begin
                w_state_nxt = SLOT_LOAD_WAIT;
                w_idx_nxt   = ex_rd_idx_i;
                w_data_nxt  = '0;
            end else begin
                w_state_nxt = SLOT_READY;
                w_idx_nxt   = ex_rd_idx_i;
                w_data_nxt  = ex_result_i;
            end
        end else begin
            // Load data arriving under a downstream stall is parked in the slot.
            if (r_state == SLOT_LOAD_WAIT && mem_load_valid_i) begin
                w_state_nxt = SLOT_READY;
                w_data_nxt  = mem_load_data_i;
            end
            // Not stalled yet not advancing: WB drains and a bubble follows.
            if (!stall_i) w_wb_clear = 1'b1;
        end
    end

    rd_slot #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_wb_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_wb_load),
        .clear_i (w_wb_clear),
        .valid_i (w_wb_valid_in),
        .idx_i   (w_wb_idx_in),
        .data_i  (w_wb_data_in),
        .valid_o (w_wb_valid),
        .idx_o   (w_wb_idx),
        .data_o  (w_wb_data)
    );

    assign rd_idx_ex_o      = (r_state == SLOT_READY) ? r_idx : '0;
    assign rd_ex_o          = (rd_idx_ex_o != '0) ? r_data : '0;
    assign rd_idx_mem_o     = w_wb_valid ? w_wb_idx  : '0;
    assign rd_mem_o         = w_wb_valid ? w_wb_data : '0;
    assign wb_we_o          = w_wb_valid && !stall_i;
    assign wb_idx_o         = rd_idx_mem_o;
    assign wb_data_o        = rd_mem_o;
    assign ex_ready_o       = w_advance;
    assign load_use_stall_o = (r_state == SLOT_LOAD_WAIT) &&
                              ((r_idx == id_rs1_idx_i) || (r_idx == id_rs2_idx_i));

endmodule

// File: tb/tb_rd_track_pipe.sv
// Directed bench for rd_track_pipe: forwarding latency, loads, stalls, flush, reset.
module tb_rd_track_pipe;

    localparam int DW = 64;
    localparam int IW = 5;

    logic          clk, rst;
    logic          ex_valid, ex_rd_we, ex_is_load, flush, stall, mem_valid;
    logic [IW-1:0] ex_rd_idx, id_rs1, id_rs2;
    logic [DW-1:0] ex_result, mem_data;
    logic [IW-1:0] rd_idx_ex, rd_idx_mem, wb_idx;
    logic [DW-1:0] rd_ex, rd_mem, wb_data;
    logic          wb_we, ex_ready, lus;

    int n_cmp = 0;
    int n_err = 0;

    rd_track_pipe #(.DATA_W(DW), .IDX_W(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_rd_we_i(ex_rd_we), .ex_is_load_i(ex_is_load),
        .ex_rd_idx_i(ex_rd_idx), .ex_result_i(ex_result),
        .flush_i(flush), .stall_i(stall),
        .mem_load_valid_i(mem_valid), .mem_load_data_i(mem_data),
        .id_rs1_idx_i(id_rs1), .id_rs2_idx_i(id_rs2),
        .rd_idx_ex_o(rd_idx_ex), .rd_ex_o(rd_ex),
        .rd_idx_mem_o(rd_idx_mem), .rd_mem_o(rd_mem),
        .wb_we_o(wb_we), .wb_idx_o(wb_idx), .wb_data_o(wb_data),
        .ex_ready_o(ex_ready), .load_use_stall_o(lus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; ex_rd_idx = '0; ex_result = '0;
        flush = 0; stall = 0; mem_valid = 0; mem_data = '0; id_rs1 = '0; id_rs2 = '0;
    endtask

    task automatic drive_alu(input logic [IW-1:0] idx, input logic [DW-1:0] val);
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 0; ex_rd_idx = idx; ex_result = val;
    endtask

    task automatic drain();
        idle();
        tick(); tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1; #1;
        n_cmp++;
        if ({rd_idx_ex, rd_ex, rd_idx_mem, rd_mem, wb_we, wb_idx, wb_data, lus} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero output, expected all zero");
        end
        n_cmp++;
        if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ex_ready); end
        stall = 1; #1;
        n_cmp++;
        if (ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_stall: got %b expected 0", ex_ready); end
        stall = 0;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_alu();
        drain();
        drive_alu(5'd5, 64'h1234);
        tick(); idle(); #1;
        n_cmp++;
        if (rd_idx_ex !== 5'd5 || rd_ex !== 64'h1234 || wb_we !== 1'b0) begin
            n_err++; $display("FAIL alu_ex: got idx=%0d data=%h we=%b expected 5 1234 0", rd_idx_ex, rd_ex, wb_we);
        end
        tick();
        n_cmp++;
        if (wb_we !== 1'b1 || wb_idx !== 5'd5 || wb_data !== 64'h1234 || rd_idx_ex !== 5'd0) begin
            n_err++; $display("FAIL alu_wb: got we=%b idx=%0d data=%h exidx=%0d expected 1 5 1234 0", wb_we, wb_idx, wb_data, rd_idx_ex);
        end
        tick();
        n_cmp++;
        if (wb_we !== 1'b0) begin n_err++; $display("FAIL alu_once: got we=%b expected 0", wb_we); end
    endtask

    task automatic test_load_use();
        drain();
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd_idx = 5'd7; ex_result = 64'hDEAD;
        id_rs1 = 5'd7;
        tick();
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (lus !== 1'b1 || ex_ready !== 1'b0 || rd_idx_ex !== 5'd0) begin
                n_err++; $display("FAIL load_wait_c%0d: got lus=%b ready=%b exidx=%0d expected 1 0 0", c, lus, ex_ready, rd_idx_ex);
            end
            tick();
        end
        mem_valid = 1; mem_data = 64'hCAFE_F00D_1234_5678; #1;
        n_cmp++;
        if (ex_ready !== 1'b1) begin n_err++; $display("FAIL load_return_ready: got %b expected 1", ex_ready); end
        tick();
        mem_valid = 0; mem_data = '0; #1;
        n_cmp++;
        if (rd_idx_mem !== 5'd7 || rd_mem !== 64'hCAFE_F00D_1234_5678 || wb_we !== 1'b1 || lus !== 1'b0) begin
            n_err++; $display("FAIL load_wb: got idx=%0d data=%h we=%b lus=%b expected 7 cafef00d12345678 1 0", rd_idx_mem, rd_mem, wb_we, lus);
        end
    endtask

    task automatic test_load_latch();
        drain();
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd_idx = 5'd4;
        id_rs2 = 5'd4;
        tick();
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; #1;
        n_cmp++;
        if (lus !== 1'b1) begin n_err++; $display("FAIL latch_lus_rs2: got %b expected 1", lus); end
        stall = 1; mem_valid = 1; mem_data = 64'h55AA; 
        tick();
        mem_valid = 0; mem_data = '0; #1;
        n_cmp++;
        if (rd_idx_ex !== 5'd4 || rd_ex !== 64'h55AA || lus !== 1'b0 || wb_we !== 1'b0) begin
            n_err++; $display("FAIL latch_ready: got idx=%0d data=%h lus=%b we=%b expected 4 55aa 0 0", rd_idx_ex, rd_ex, lus, wb_we);
        end
        stall = 0;
        tick();
        n_cmp++;
        if (wb_we !== 1'b1 || wb_idx !== 5'd4 || wb_data !== 64'h55AA) begin
            n_err++; $display("FAIL latch_wb: got we=%b idx=%0d data=%h expected 1 4 55aa", wb_we, wb_idx, wb_data);
        end
    endtask

    task automatic test_rd_zero();
        int writes;
        drain();
        writes = 0;
        drive_alu(5'd0, 64'hFFFF);
        tick(); idle(); #1;
        n_cmp++;
        if (rd_idx_ex !== 5'd0 || rd_ex !== 64'd0) begin
            n_err++; $display("FAIL zero_ex: got idx=%0d data=%h expected 0 0", rd_idx_ex, rd_ex);
        end
        for (int c = 0; c < 3; c++) begin
            if (wb_we === 1'b1) writes++;
            tick();
        end
        n_cmp++;
        if (writes !== 0) begin n_err++; $display("FAIL zero_writes: got %0d expected 0", writes); end
    endtask

    task automatic test_stall();
        int writes;
        drain();
        writes = 0;
        drive_alu(5'd3, 64'h33);
        tick(); idle();
        tick();
        stall = 1; #1;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (wb_we !== 1'b0 || wb_idx !== 5'd3 || ex_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_c%0d: got we=%b idx=%0d ready=%b expected 0 3 0", c, wb_we, wb_idx, ex_ready);
            end
            tick();
        end
        stall = 0; #1;
        for (int c = 0; c < 3; c++) begin
            if (wb_we === 1'b1 && wb_idx === 5'd3 && wb_data === 64'h33) writes++;
            tick();
        end
        n_cmp++;
        if (writes !== 1) begin n_err++; $display("FAIL stall_writes: got %0d expected 1", writes); end
    endtask

    task automatic test_flush();
        drain();
        drive_alu(5'd9, 64'h99);
        flush = 1;
        tick(); idle(); #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (rd_idx_ex !== 5'd0 || rd_idx_mem !== 5'd0 || wb_we !== 1'b0) begin
                n_err++; $display("FAIL flush_c%0d: got exidx=%0d memidx=%0d we=%b expected 0 0 0", c, rd_idx_ex, rd_idx_mem, wb_we);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        drain();
        ex_valid = 1; ex_rd_we = 1; ex_is_load = 1; ex_rd_idx = 5'd6;
        id_rs1 = 5'd6;
        tick();
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; #1;
        n_cmp++;
        if (lus !== 1'b1) begin n_err++; $display("FAIL midload_lus: got %b expected 1", lus); end
        rst = 1; #1;
        n_cmp++;
        if (lus !== 1'b0 || ex_ready !== 1'b1) begin
            n_err++; $display("FAIL midload_rst: got lus=%b ready=%b expected 0 1", lus, ex_ready);
        end
        tick();
        rst = 0;
        mem_valid = 1; mem_data = 64'hBAD0;
        tick();
        mem_valid = 0; mem_data = '0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if ({rd_idx_ex, rd_ex, rd_idx_mem, rd_mem, wb_we, wb_idx, wb_data, lus} !== '0) begin
                n_err++; $display("FAIL midload_late_c%0d: got memidx=%0d mem=%h we=%b expected all zero", c, rd_idx_mem, rd_mem, wb_we);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drain();
        drive_alu(5'd1, 64'h11);
        tick();
        drive_alu(5'd2, 64'h22); #1;
        n_cmp++;
        if (rd_idx_ex !== 5'd1 || rd_ex !== 64'h11) begin
            n_err++; $display("FAIL b2b_c1: got idx=%0d data=%h expected 1 11", rd_idx_ex, rd_ex);
        end
        tick(); idle(); #1;
        n_cmp++;
        if (rd_idx_ex !== 5'd2 || rd_ex !== 64'h22 || wb_idx !== 5'd1 || wb_data !== 64'h11 || wb_we !== 1'b1) begin
            n_err++; $display("FAIL b2b_c2: got ex=%0d/%h wb=%0d/%h we=%b expected 2/22 1/11 1", rd_idx_ex, rd_ex, wb_idx, wb_data, wb_we);
        end
        tick();
        n_cmp++;
        if (rd_idx_ex !== 5'd0 || wb_idx !== 5'd2 || wb_data !== 64'h22 || wb_we !== 1'b1) begin
            n_err++; $display("FAIL b2b_c3: got ex=%0d wb=%0d/%h we=%b expected 0 2/22 1", rd_idx_ex, wb_idx, wb_data, wb_we);
        end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alu();
        test_load_use();
        test_load_latch();
        test_rd_zero();
        test_stall();
        test_flush();
        test_reset_mid_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rd_track_pipe.md
RD_TRACK_PIPE -- requirements
Module: rd_track_pipe

Interface
REQ-001 The block SHALL have parameters, one per line: DATA_W, default 64, datapath width; IDX_W, default 5, register index width.
REQ-002 The block SHALL have ports, one per line: clk_i  in  1  single clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-003 ex_valid_i  in  1  EX holds a live instruction; ex_rd_we_i  in  1  instruction writes rd; ex_is_load_i  in  1  instruction is a load; ex_rd_idx_i  in  IDX_W  destination index; ex_result_i  in  DATA_W  ALU result or load address-phase value (ignored for loads).
REQ-004 flush_i  in  1  kill the EX instruction being captured; stall_i  in  1  downstream hold of the WB slot.
REQ-005 mem_load_valid_i  in  1  load data returns this cycle; mem_load_data_i  in  DATA_W  returned load data.
REQ-006 id_rs1_idx_i, id_rs2_idx_i  in  IDX_W  source indices of the decoding instruction.
REQ-007 rd_idx_ex_o  out  IDX_W; rd_ex_o  out  DATA_W  forwarding view of the MEM slot; rd_idx_mem_o  out  IDX_W; rd_mem_o  out  DATA_W  forwarding view of the WB slot.
REQ-008 wb_we_o  out  1; wb_idx_o  out  IDX_W; wb_data_o  out  DATA_W  register-file write port.
REQ-009 ex_ready_o  out  1  MEM slot accepts EX this cycle; load_use_stall_o  out  1  decode must hold.

Function
REQ-010 The MEM slot SHALL be a state machine with states EMPTY, READY, LOAD_WAIT, holding idx and data.
REQ-011 advance SHALL equal !stall_i && !(state==LOAD_WAIT && !mem_load_valid_i); ex_ready_o SHALL equal advance.
REQ-012 On advance, MEM slot SHALL capture: EMPTY if flush_i or !ex_valid_i or !ex_rd_we_i or ex_rd_idx_i==0; else LOAD_WAIT if ex_is_load_i; else READY with data=ex_result_i.
REQ-013 In LOAD_WAIT with mem_load_valid_i and no advance, the slot SHALL latch mem_load_data_i and move to READY; data SHALL never be dropped.
REQ-014 In LOAD_WAIT with mem_load_valid_i and advance, the WB slot SHALL receive mem_load_data_i directly.
REQ-015 The WB slot SHALL load the MEM slot on advance (bubble if EMPTY), hold when stall_i, and become empty when advance is blocked only by LOAD_WAIT.
REQ-016 rd_idx_ex_o SHALL be the MEM slot idx when READY, else 0; rd_ex_o SHALL be 0 whenever rd_idx_ex_o is 0.
REQ-017 rd_idx_mem_o/rd_mem_o SHALL be the WB slot idx/data when valid, else 0/0.
REQ-018 wb_we_o SHALL equal WB valid && !stall_i; wb_idx_o/wb_data_o SHALL mirror rd_idx_mem_o/rd_mem_o; each entry SHALL write exactly once.
REQ-019 load_use_stall_o SHALL be combinational: MEM state LOAD_WAIT and its idx equals id_rs1_idx_i or id_rs2_idx_i.
REQ-020 Index 0 SHALL never be presented as valid on any output.
REQ-021 Latency: ALU result SHALL appear on rd_ex_o one cycle after capture and on wb_data_o one cycle later, absent stalls.

Reset
REQ-022 While rst_i is high, both slots SHALL be empty/EMPTY, and all outputs SHALL be 0 except ex_ready_o, which SHALL follow REQ-011 with stall_i.
REQ-023 Reset asserted mid-load SHALL discard the pending load; a mem_load_valid_i arriving in EMPTY SHALL be ignored.

Structure
REQ-024 Slot-state encoding and DATA_W/IDX_W defaults SHALL live in the shared defines package, alongside REG_IDX/DATA_LEN.
REQ-025 One sub-module, rd_slot (idx/data/valid register with load/hold/clear), SHALL be instantiated for the WB slot.

Verification
REQ-026 ALU add rd=5 result 0x1234 -> cycle+1 rd_idx_ex_o=5, rd_ex_o=0x1234; cycle+2 wb_we_o=1, wb_idx_o=5, wb_data_o=0x1234.
REQ-027 Load rd=7 with id_rs1_idx_i=7, data after 3 cycles -> load_use_stall_o=1 and ex_ready_o=0 for 3 cycles; then rd_idx_mem_o=7, rd_mem_o=loaded value.
REQ-028 Write to rd=0 with result 0xFFFF -> rd_idx_ex_o=0, rd_ex_o=0, wb_we_o never 1.
REQ-029 stall_i high 4 cycles with rd=3 in WB -> wb_we_o=0 for 4 cycles, exactly one write of rd=3 after release.
REQ-030 flush_i with valid rd=9 -> no idx 9 on any output; rst_i pulse during LOAD_WAIT, then late mem_load_valid_i -> all outputs stay 0.
